// File: rtl/motoro3_seq_pkg.sv
//------------------------------------------------------------------------------
// motoro3_seq_pkg
// Shared widths, FSM state codes and the active-config bundle for the
// 3-phase step sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package motoro3_seq_pkg;

  localparam int unsigned POWER_W    = 8;
  localparam int unsigned SPEED_W    = 25;
  localparam int unsigned PWM_LEN_W  = 12;
  localparam int unsigned PWM_MASK_W = 12;
  localparam int unsigned SPLIT_W    = 2;
  localparam int unsigned STEP_W     = 4;
  localparam int unsigned LEN_W      = 16;

  typedef logic [1:0] seq_state_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOAD     = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_STOPPING = 2'd3;

  typedef struct packed {
    logic [POWER_W-1:0]    power_percent;
    logic [SPEED_W-1:0]    step_cnt_speed_set;
    logic [PWM_LEN_W-1:0]  pwm_len_want;
    logic [PWM_MASK_W-1:0] pwm_min_mask;
    logic [SPLIT_W-1:0]    step_split_max;
  } m3r_cfg_t;

  function automatic logic [SPEED_W-1:0] clamp_period(
    input logic [SPEED_W-1:0] req,
    input logic [SPEED_W-1:0] min_clks
  );
    return (req < min_clks) ? min_clks : req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/motoro3_step_timer.sv
//------------------------------------------------------------------------------
// motoro3_step_timer
// Step period timer: clamps the requested period and emits a terminal-count
// pulse in the last clock of each step.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module motoro3_step_timer
  import motoro3_seq_pkg::*;
#(
  parameter int unsigned MIN_STEP_CLKS = 64
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               en,
  input  logic               clr,
  input  logic [SPEED_W-1:0] period_req,
  output logic               tc
);

  logic [SPEED_W-1:0] period;
  logic [SPEED_W-1:0] count_q;
  logic [SPEED_W-1:0] count_d;

  always_comb begin
    period  = clamp_period(period_req, SPEED_W'(MIN_STEP_CLKS));
    tc      = en && !clr && (count_q == (period - SPEED_W'(1)));
    count_d = count_q + SPEED_W'(1);
    if (!en || clr || tc) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/motoro3_step_sequencer.sv
//------------------------------------------------------------------------------
// motoro3_step_sequencer
// Commutation step sequencer with shadowed calculator config and per-step
// length capture. Optional macro MOTORO3_SEQ_DIR_EN adds a `dir` input.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module motoro3_step_sequencer
  import motoro3_seq_pkg::*;
#(
  parameter int unsigned STEP_NUM      = 12,
  parameter int unsigned MIN_STEP_CLKS = 64
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  abort,
`ifdef MOTORO3_SEQ_DIR_EN
  input  logic                  dir,
`endif
  input  logic                  cfg_update,
  input  logic [POWER_W-1:0]    cfg_power_percent,
  input  logic [SPEED_W-1:0]    cfg_stepCNT_speedSET,
  input  logic [PWM_LEN_W-1:0]  cfg_pwmLenWant,
  input  logic [PWM_MASK_W-1:0] cfg_pwmMinMask,
  input  logic [SPLIT_W-1:0]    cfg_stepSplitMax,
  output logic [POWER_W-1:0]    m3r_power_percent,
  output logic [SPEED_W-1:0]    m3r_stepCNT_speedSET,
  output logic [PWM_LEN_W-1:0]  m3r_pwmLenWant,
  output logic [PWM_MASK_W-1:0] m3r_pwmMinMask,
  output logic [SPLIT_W-1:0]    m3r_stepSplitMax,
  output logic [STEP_W-1:0]     lcStep,
  input  logic [LEN_W-1:0]      plLen,
  input  logic [LEN_W-1:0]      slLen,
  output logic [LEN_W-1:0]      plLen_q,
  output logic [LEN_W-1:0]      slLen_q,
  output logic                  len_valid,
  output logic                  step_tick,
  output logic                  running,
  output logic                  cfg_pending
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_NUM - 1);

  seq_state_t        state_q, state_d;
  m3r_cfg_t          active_q, active_d;
  m3r_cfg_t          shadow_q, shadow_d;
  m3r_cfg_t          cfg_in;
  logic [STEP_W-1:0] lc_step_q, lc_step_d;
  logic [LEN_W-1:0]  pl_len_q, pl_len_d;
  logic [LEN_W-1:0]  sl_len_q, sl_len_d;
  logic              len_valid_q, len_valid_d;
  logic              step_tick_q, step_tick_d;
  logic              cfg_pending_q, cfg_pending_d;
  logic              cap_req_q, cap_req_d;

  logic              dir_w;
  logic              stepping;
  logic              timer_tc;
  logic [STEP_W-1:0] step_next;
  logic              step_wrap;

`ifdef MOTORO3_SEQ_DIR_EN
  assign dir_w = dir;
`else
  assign dir_w = 1'b0;
`endif

  assign stepping = (state_q == ST_RUN) || (state_q == ST_STOPPING);

  motoro3_step_timer #(
    .MIN_STEP_CLKS (MIN_STEP_CLKS)
  ) u_timer (
    .clk        (clk),
    .nRst       (nRst),
    .en         (stepping),
    .clr        (abort),
    .period_req (active_q.step_cnt_speed_set),
    .tc         (timer_tc)
  );

  always_comb begin
    cfg_in.power_percent      = cfg_power_percent;
    cfg_in.step_cnt_speed_set = cfg_stepCNT_speedSET;
    cfg_in.pwm_len_want       = cfg_pwmLenWant;
    cfg_in.pwm_min_mask       = cfg_pwmMinMask;
    cfg_in.step_split_max     = cfg_stepSplitMax;
  end

  // The wrap step is where config applies and a graceful stop completes.
  always_comb begin
    if (dir_w) begin
      step_next = (lc_step_q == '0) ? STEP_LAST : lc_step_q - STEP_W'(1);
      step_wrap = (step_next == STEP_LAST);
    end else begin
      step_next = (lc_step_q == STEP_LAST) ? '0 : lc_step_q + STEP_W'(1);
      step_wrap = (step_next == '0);
    end
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    lc_step_d     = lc_step_q;
    pl_len_d      = pl_len_q;
    sl_len_d      = sl_len_q;
    len_valid_d   = 1'b0;
    step_tick_d   = 1'b0;
    cfg_pending_d = cfg_pending_q;
    cap_req_d     = cap_req_q;

    if (cfg_update) begin
      shadow_d      = cfg_in;
      cfg_pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        lc_step_d = '0;
        pl_len_d  = '0;
        sl_len_d  = '0;
        cap_req_d = 1'b0;
        if (start && !stop && !abort) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (stop || abort) begin
          state_d = ST_IDLE;
        end else begin
          active_d      = cfg_update ? cfg_in : shadow_q;
          cfg_pending_d = 1'b0;
          lc_step_d     = '0;
          cap_req_d     = 1'b1;
          state_d       = ST_RUN;
        end
      end

      ST_RUN, ST_STOPPING: begin
        if (abort) begin
          state_d   = ST_IDLE;
          lc_step_d = '0;
          pl_len_d  = '0;
          sl_len_d  = '0;
          cap_req_d = 1'b0;
        end else begin
          if (cap_req_q) begin
            pl_len_d    = plLen;
            sl_len_d    = slLen;
            len_valid_d = 1'b1;
            cap_req_d   = 1'b0;
          end
          if ((state_q == ST_RUN) && stop) begin
            state_d = ST_STOPPING;
          end
          if (timer_tc) begin
            lc_step_d   = step_next;
            step_tick_d = 1'b1;
            cap_req_d   = 1'b1;
            if (step_wrap) begin
              active_d      = cfg_update ? cfg_in : shadow_q;
              cfg_pending_d = 1'b0;
              if (state_q == ST_STOPPING) begin
                state_d     = ST_IDLE;
                lc_step_d   = '0;
                pl_len_d    = '0;
                sl_len_d    = '0;
                len_valid_d = 1'b0;
                cap_req_d   = 1'b0;
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q       <= ST_IDLE;
      active_q      <= '0;
      shadow_q      <= '0;
      lc_step_q     <= '0;
      pl_len_q      <= '0;
      sl_len_q      <= '0;
      len_valid_q   <= 1'b0;
      step_tick_q   <= 1'b0;
      cfg_pending_q <= 1'b0;
      cap_req_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      lc_step_q     <= lc_step_d;
      pl_len_q      <= pl_len_d;
      sl_len_q      <= sl_len_d;
      len_valid_q   <= len_valid_d;
      step_tick_q   <= step_tick_d;
      cfg_pending_q <= cfg_pending_d;
      cap_req_q     <= cap_req_d;
    end
  end

  assign m3r_power_percent    = active_q.power_percent;
  assign m3r_stepCNT_speedSET = active_q.step_cnt_speed_set;
  assign m3r_pwmLenWant       = active_q.pwm_len_want;
  assign m3r_pwmMinMask       = active_q.pwm_min_mask;
  assign m3r_stepSplitMax     = active_q.step_split_max;
  assign lcStep               = lc_step_q;
  assign plLen_q              = pl_len_q;
  assign slLen_q              = sl_len_q;
  assign len_valid            = len_valid_q;
  assign step_tick            = step_tick_q;
  assign running              = (state_q != ST_IDLE);
  assign cfg_pending          = cfg_pending_q;

endmodule

`default_nettype wire

// File: tb/tb_motoro3_step_sequencer.sv
//------------------------------------------------------------------------------
// tb_motoro3_step_sequencer
// Directed scenarios followed by random traffic, checked cycle by cycle
// against a transaction-level model of the sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_motoro3_step_sequencer;

  localparam int N    = 12;
  localparam int MINP = 64;

  logic        clk = 1'b0;
  logic        nRst = 1'b0, start = 1'b0, stop = 1'b0, abort = 1'b0;
  logic        cfg_update = 1'b0, dir = 1'b0;
  logic [7:0]  cfg_power_percent = '0;
  logic [24:0] cfg_stepCNT_speedSET = '0;
  logic [11:0] cfg_pwmLenWant = '0, cfg_pwmMinMask = '0;
  logic [1:0]  cfg_stepSplitMax = '0;
  logic [7:0]  m3r_power_percent;
  logic [24:0] m3r_stepCNT_speedSET;
  logic [11:0] m3r_pwmLenWant, m3r_pwmMinMask;
  logic [1:0]  m3r_stepSplitMax;
  logic [3:0]  lcStep;
  logic [15:0] plLen, slLen, plLen_q, slLen_q;
  logic        len_valid, step_tick, running, cfg_pending;

  always #5 clk = ~clk;

  // Stand-in for the line-parameter calculator: results encode step and config.
  assign plLen = {lcStep, 4'h0, m3r_power_percent};
  assign slLen = {m3r_pwmLenWant, lcStep};

  motoro3_step_sequencer #(.STEP_NUM(N), .MIN_STEP_CLKS(MINP)) dut (
    .clk                  (clk),
    .nRst                 (nRst),
    .start                (start),
    .stop                 (stop),
    .abort                (abort),
`ifdef MOTORO3_SEQ_DIR_EN
    .dir                  (dir),
`endif
    .cfg_update           (cfg_update),
    .cfg_power_percent    (cfg_power_percent),
    .cfg_stepCNT_speedSET (cfg_stepCNT_speedSET),
    .cfg_pwmLenWant       (cfg_pwmLenWant),
    .cfg_pwmMinMask       (cfg_pwmMinMask),
    .cfg_stepSplitMax     (cfg_stepSplitMax),
    .m3r_power_percent    (m3r_power_percent),
    .m3r_stepCNT_speedSET (m3r_stepCNT_speedSET),
    .m3r_pwmLenWant       (m3r_pwmLenWant),
    .m3r_pwmMinMask       (m3r_pwmMinMask),
    .m3r_stepSplitMax     (m3r_stepSplitMax),
    .lcStep               (lcStep),
    .plLen                (plLen),
    .slLen                (slLen),
    .plLen_q              (plLen_q),
    .slLen_q              (slLen_q),
    .len_valid            (len_valid),
    .step_tick            (step_tick),
    .running              (running),
    .cfg_pending          (cfg_pending)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 load, 2 run, 3 stopping.
  typedef struct {
    int power;
    int speed;
    int len;
    int mask;
    int split;
  } cfg_s;

  cfg_s m_act   = '{0, 0, 0, 0, 0};
  cfg_s m_shd   = '{0, 0, 0, 0, 0};
  int   m_mode = 0, m_step = 0, m_elapsed = 0, m_pl = 0, m_sl = 0;
  bit   m_pend = 0, m_cap = 0, m_lv = 0, m_tick = 0;
  int   cyc = 0, last_tick = 0;
  bit   last_tick_ok = 0;

  task automatic m_go_idle();
    m_mode = 0; m_step = 0; m_pl = 0; m_sl = 0; m_cap = 0; m_elapsed = 0;
  endtask

  task automatic model_edge();
    cfg_s in_c, old_shd;
    int   period;
    in_c = '{int'(cfg_power_percent), int'(cfg_stepCNT_speedSET), int'(cfg_pwmLenWant),
             int'(cfg_pwmMinMask), int'(cfg_stepSplitMax)};
    if (!nRst) begin
      m_go_idle();
      m_act = '{0, 0, 0, 0, 0}; m_shd = '{0, 0, 0, 0, 0};
      m_pend = 0; m_lv = 0; m_tick = 0;
      return;
    end
    m_tick = 0; m_lv = 0;
    old_shd = m_shd;
    if (cfg_update) begin m_shd = in_c; m_pend = 1; end
    case (m_mode)
      0: begin
        m_go_idle();
        if (start && !stop && !abort) m_mode = 1;
      end
      1: begin
        if (stop || abort) m_mode = 0;
        else begin
          m_act = cfg_update ? in_c : old_shd;
          m_pend = 0; m_step = 0; m_elapsed = 0; m_cap = 1; m_mode = 2;
        end
      end
      default: begin
        if (abort) m_go_idle();
        else begin
          if (m_cap) begin
            m_pl = m_step * 4096 + m_act.power;
            m_sl = m_act.len * 16 + m_step;
            m_lv = 1; m_cap = 0;
          end
          period = (m_act.speed > MINP) ? m_act.speed : MINP;
          m_elapsed++;
          if (m_elapsed == period) begin
            m_elapsed = 0; m_tick = 1; m_cap = 1;
            m_step = dir ? (m_step + N - 1) % N : (m_step + 1) % N;
            if (m_step == (dir ? N - 1 : 0)) begin
              m_act = cfg_update ? in_c : old_shd;
              m_pend = 0;
              if (m_mode == 3) begin m_go_idle(); m_lv = 0; end
            end
          end
          if (m_mode == 2 && stop) m_mode = 3;
        end
      end
    endcase
  endtask

  task automatic cycle();
    int pre_period;
    bit pre_stepping;
    pre_period   = (m_act.speed > MINP) ? m_act.speed : MINP;
    pre_stepping = (m_mode >= 2);
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check("running",     running,     m_mode != 0);
    check("lcStep",      lcStep,      m_step);
    check("step_tick",   step_tick,   m_tick);
    check("len_valid",   len_valid,   m_lv);
    check("plLen_q",     plLen_q,     m_pl);
    check("slLen_q",     slLen_q,     m_sl);
    check("cfg_pending", cfg_pending, m_pend);
    check("m3r_power",   m3r_power_percent,    m_act.power);
    check("m3r_speed",   m3r_stepCNT_speedSET, m_act.speed);
    check("m3r_misc", {m3r_pwmLenWant, m3r_pwmMinMask, m3r_stepSplitMax},
          m_act.len * 16384 + m_act.mask * 4 + m_act.split);
    if (step_tick && pre_stepping) begin
      if (last_tick_ok) check("tick_period", cyc - last_tick, pre_period);
      last_tick = cyc; last_tick_ok = 1;
    end
    if (m_mode < 2) last_tick_ok = 0;
    start = 0; stop = 0; abort = 0; cfg_update = 0; nRst = 1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_cfg(input int p, input int sp, input int ln, input int mk, input int sl);
    cfg_power_percent    = 8'(p);
    cfg_stepCNT_speedSET = 25'(sp);
    cfg_pwmLenWant       = 12'(ln);
    cfg_pwmMinMask       = 12'(mk);
    cfg_stepSplitMax     = 2'(sl);
    cfg_update           = 1'b1;
  endtask

  task automatic wait_step(input int s, input int bound);
    int k = 0;
    while (m_step != s && k < bound) begin cycle(); k++; end
    check("wait_lcStep", lcStep, s);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (m_mode != 0 && k < bound) begin cycle(); k++; end
    check("wait_idle_running", running, 0);
  endtask

  initial begin
    int r;
    repeat (3) begin nRst = 0; cycle(); end
    check("rst_step", lcStep, 0);

    // Start at period 100, run one full electrical cycle.
    set_cfg(50, 100, 12'h123, 12'h0f0, 2);
    cycle();
    start = 1; cycle();
    check("load_running", running, 1);
    cycle();
    run(N * 100 + 5);

    // Config change mid-cycle, applied at wrap; new period clamps to 64.
    wait_step(4, 2000);
    set_cfg(200, 5, 12'h456, 12'h00f, 1);
    cycle();
    check("pend_set", cfg_pending, 1);
    check("power_hold", m3r_power_percent, 50);
    wait_step(0, 2000);
    check("power_apply", m3r_power_percent, 200);
    check("pend_clear", cfg_pending, 0);
    run(200);

    // Graceful stop.
    wait_step(7, 2000);
    stop = 1; cycle();
    wait_idle(2000);
    check("stop_plLen_q", plLen_q, 0);
    check("stop_lcStep", lcStep, 0);

    // Abort mid-period, then start colliding with stop.
    set_cfg(77, 100, 12'h321, 12'h111, 3);
    cycle();
    start = 1; cycle(); cycle();
    wait_step(3, 2000);
    run(30);
    abort = 1; cycle();
    check("abort_running", running, 0);
    check("abort_lcStep", lcStep, 0);
    run(300);
    start = 1; stop = 1; cycle();
    run(3);
    check("start_stop_idle", running, 0);

    // Reset while stopping.
    start = 1; cycle(); cycle();
    stop = 1; cycle();
    run(150);
    nRst = 0; cycle();
    check("rst_running", running, 0);
    check("rst_power", m3r_power_percent, 0);
    check("rst_pending", cfg_pending, 0);

    // Random traffic.
    repeat (20000) begin
      r     = $urandom_range(0, 9999);
      nRst  = (r >= 3);
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 999) == 0);
      abort = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 149) == 0)
        set_cfg($urandom_range(0, 255), $urandom_range(0, 120), $urandom_range(0, 4095),
                $urandom_range(0, 4095), $urandom_range(0, 3));
`ifdef MOTORO3_SEQ_DIR_EN
      dir = 1'($urandom_range(0, 1));
`endif
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
